// File: rtl/rv_pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: FSM state
// encodings, the drain length and the per-stage control bundle.
package rv_pipe_ctrl_pkg;

   localparam logic [1:0] PC_ST_RUN   = 2'd0;
   localparam logic [1:0] PC_ST_DRAIN = 2'd1;
   localparam logic [1:0] PC_ST_HALT  = 2'd2;
   localparam logic [1:0] PC_ST_ERR   = 2'd3;

   // Number of advancing cycles spent in DRAIN before HALT is entered.
   localparam logic [2:0] PC_DRAIN_CYC = 3'd4;

   typedef struct packed {
      logic stallIf;
      logic stallId;
      logic stallEx;
      logic stallMem;
      logic flushId;
      logic flushEx;
      logic bubbleMem;
      logic bubbleWb;
      logic redirect;
   } pc_ctrl_t;

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module rv_sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] count_q;

   // Count up on each increment request and stick at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (i_inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Pipeline sequencing controller: merges memory freeze, load-use stall and
// EX-stage branch redirect into per-stage controls, and runs the
// halt/drain/resume FSM, the data-memory watchdog and the perf counters.
module rv_pipe_ctrl
   import rv_pipe_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pc_load_use,
   input  logic             i_pc_br_taken_ex,
   input  logic             i_pc_dmem_req_mem,
   input  logic             i_pc_dmem_ack,
   input  logic             i_pc_halt_req,
   input  logic             i_pc_resume,
   output logic             o_pc_stall_if,
   output logic             o_pc_stall_id,
   output logic             o_pc_stall_ex,
   output logic             o_pc_stall_mem,
   output logic             o_pc_flush_id,
   output logic             o_pc_flush_ex,
   output logic             o_pc_bubble_mem,
   output logic             o_pc_bubble_wb,
   output logic             o_pc_redirect,
   output logic             o_pc_halted,
   output logic             o_pc_err,
   output logic [CNT_W-1:0] o_pc_stall_cnt,
   output logic [CNT_W-1:0] o_pc_flush_cnt
);

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [2:0]        drain_q, drain_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic     frozen, lu, br, active, advancing, timeout;
   pc_ctrl_t ctrl;

   assign frozen    = i_pc_dmem_req_mem & ~i_pc_dmem_ack;
   assign lu        = i_pc_load_use & ~frozen;
   assign br        = i_pc_br_taken_ex & ~frozen & ~lu;
   assign active    = (state_q == PC_ST_RUN) || (state_q == PC_ST_DRAIN);
   assign advancing = ~frozen & ~lu;
   assign timeout   = frozen && (wait_q == WAIT_LAST);

   // Prioritised per-stage controls: freeze beats load-use beats branch,
   // with DRAIN additionally holding the PC and discarding the IF slot.
   always_comb begin
      ctrl = '0;
      case (state_q)
         PC_ST_RUN, PC_ST_DRAIN: begin
            if (frozen) begin
               ctrl.stallIf  = 1'b1;
               ctrl.stallId  = 1'b1;
               ctrl.stallEx  = 1'b1;
               ctrl.stallMem = 1'b1;
               ctrl.bubbleWb = 1'b1;
            end else if (lu) begin
               ctrl.stallIf   = 1'b1;
               ctrl.stallId   = 1'b1;
               ctrl.stallEx   = 1'b1;
               ctrl.bubbleMem = 1'b1;
            end else if (br) begin
               ctrl.redirect = 1'b1;
               ctrl.flushId  = 1'b1;
               ctrl.flushEx  = 1'b1;
            end
            if (state_q == PC_ST_DRAIN) begin
               ctrl.stallIf = 1'b1;
               ctrl.flushId = 1'b1;
            end
         end
         PC_ST_HALT: begin
            ctrl.stallIf = 1'b1;
            ctrl.flushId = 1'b1;
         end
         default: begin
            ctrl.stallIf  = 1'b1;
            ctrl.stallId  = 1'b1;
            ctrl.stallEx  = 1'b1;
            ctrl.stallMem = 1'b1;
            ctrl.bubbleWb = 1'b1;
         end
      endcase
   end

   // Next-state logic for the FSM, the drain counter and the watchdog.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      wait_d  = '0;
      case (state_q)
         PC_ST_RUN: begin
            if (timeout) begin
               state_d = PC_ST_ERR;
            end else begin
               wait_d = frozen ? wait_q + 1'b1 : '0;
               if (i_pc_halt_req && !frozen) begin
                  state_d = PC_ST_DRAIN;
                  drain_d = '0;
               end
            end
         end
         PC_ST_DRAIN: begin
            if (timeout) begin
               state_d = PC_ST_ERR;
            end else begin
               wait_d = frozen ? wait_q + 1'b1 : '0;
               if (advancing) begin
                  if (drain_q == PC_DRAIN_CYC - 3'd1) begin
                     state_d = PC_ST_HALT;
                     drain_d = '0;
                  end else begin
                     drain_d = drain_q + 3'd1;
                  end
               end
            end
         end
         PC_ST_HALT: begin
            if (i_pc_resume) begin
               state_d = PC_ST_RUN;
            end
         end
         default: begin
            state_d = PC_ST_ERR;
         end
      endcase
   end

   // Register FSM state and its counters; reset returns to RUN.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= PC_ST_RUN;
         drain_q <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         wait_q  <= wait_d;
      end
   end

   rv_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (active & (frozen | lu)),
      .o_count (o_pc_stall_cnt)
   );

   rv_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (ctrl.redirect),
      .o_count (o_pc_flush_cnt)
   );

   assign o_pc_stall_if   = ctrl.stallIf;
   assign o_pc_stall_id   = ctrl.stallId;
   assign o_pc_stall_ex   = ctrl.stallEx;
   assign o_pc_stall_mem  = ctrl.stallMem;
   assign o_pc_flush_id   = ctrl.flushId;
   assign o_pc_flush_ex   = ctrl.flushEx;
   assign o_pc_bubble_mem = ctrl.bubbleMem;
   assign o_pc_bubble_wb  = ctrl.bubbleWb;
   assign o_pc_redirect   = ctrl.redirect;
   assign o_pc_halted     = (state_q == PC_ST_HALT);
   assign o_pc_err        = (state_q == PC_ST_ERR);

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed self-checking bench for rv_pipe_ctrl. Two instances share the
// inputs: dutA uses a short watchdog, dutB a narrow counter for saturation.
module tb_rv_pipe_ctrl;

   logic clk = 1'b0;
   logic rst, loadUse, brTaken, dmemReq, dmemAck, haltReq, resume;

   logic aSif, aSid, aSex, aSmem, aFid, aFex, aBmem, aBwb, aRed, aHalted, aErr;
   logic [7:0] aStallCnt, aFlushCnt;
   logic bSif, bSid, bSex, bSmem, bFid, bFex, bBmem, bBwb, bRed, bHalted, bErr;
   logic [3:0] bStallCnt, bFlushCnt;

   int assertCount = 0;
   int failCount   = 0;

   // Control vector order: {stall_if, stall_id, stall_ex, stall_mem,
   // flush_id, flush_ex, bubble_mem, bubble_wb, redirect}.
   localparam logic [8:0] C_NONE   = 9'b0000_0000_0;
   localparam logic [8:0] C_FROZEN = 9'b1111_0001_0;
   localparam logic [8:0] C_LU     = 9'b1110_0010_0;
   localparam logic [8:0] C_BR     = 9'b0000_1100_1;
   localparam logic [8:0] C_DRAIN  = 9'b1000_1000_0;
   localparam logic [8:0] C_DR_LU  = 9'b1110_1010_0;

   wire [8:0] aCtrl = {aSif, aSid, aSex, aSmem, aFid, aFex, aBmem, aBwb, aRed};
   wire [8:0] bCtrl = {bSif, bSid, bSex, bSmem, bFid, bFex, bBmem, bBwb, bRed};

   always #5 clk = ~clk;

   rv_pipe_ctrl #(.CNT_W(8), .MEM_TIMEOUT(4)) dutA (
      .i_clk(clk), .i_rst(rst), .i_pc_load_use(loadUse),
      .i_pc_br_taken_ex(brTaken), .i_pc_dmem_req_mem(dmemReq),
      .i_pc_dmem_ack(dmemAck), .i_pc_halt_req(haltReq), .i_pc_resume(resume),
      .o_pc_stall_if(aSif), .o_pc_stall_id(aSid), .o_pc_stall_ex(aSex),
      .o_pc_stall_mem(aSmem), .o_pc_flush_id(aFid), .o_pc_flush_ex(aFex),
      .o_pc_bubble_mem(aBmem), .o_pc_bubble_wb(aBwb), .o_pc_redirect(aRed),
      .o_pc_halted(aHalted), .o_pc_err(aErr),
      .o_pc_stall_cnt(aStallCnt), .o_pc_flush_cnt(aFlushCnt)
   );

   rv_pipe_ctrl #(.CNT_W(4), .MEM_TIMEOUT(32)) dutB (
      .i_clk(clk), .i_rst(rst), .i_pc_load_use(loadUse),
      .i_pc_br_taken_ex(brTaken), .i_pc_dmem_req_mem(dmemReq),
      .i_pc_dmem_ack(dmemAck), .i_pc_halt_req(haltReq), .i_pc_resume(resume),
      .o_pc_stall_if(bSif), .o_pc_stall_id(bSid), .o_pc_stall_ex(bSex),
      .o_pc_stall_mem(bSmem), .o_pc_flush_id(bFid), .o_pc_flush_ex(bFex),
      .o_pc_bubble_mem(bBmem), .o_pc_bubble_wb(bBwb), .o_pc_redirect(bRed),
      .o_pc_halted(bHalted), .o_pc_err(bErr),
      .o_pc_stall_cnt(bStallCnt), .o_pc_flush_cnt(bFlushCnt)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive {load_use, br_taken, dmem_req, dmem_ack, halt_req, resume} and
   // let the combinational outputs settle.
   task automatic applyStimulus(input logic [5:0] v);
      {loadUse, brTaken, dmemReq, dmemAck, haltReq, resume} = v;
      #1;
   endtask

   // Advance one rising edge and sample just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(6'b000000);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      rst = 1'b1;
      {loadUse, brTaken, dmemReq, dmemAck, haltReq, resume} = '0;
      doReset();

      // Reset state
      checkOutput("reset_ctrl", 32'(aCtrl), 32'(C_NONE));
      checkOutput("reset_halted", 32'(aHalted), 32'd0);
      checkOutput("reset_err", 32'(aErr), 32'd0);
      checkOutput("reset_stall_cnt", 32'(aStallCnt), 32'd0);
      checkOutput("reset_flush_cnt", 32'(aFlushCnt), 32'd0);

      // Load-use and branch together: load-use wins
      applyStimulus(6'b110000);
      checkOutput("lu_br_ctrl", 32'(aCtrl), 32'(C_LU));
      tick();
      checkOutput("lu_br_stall_cnt", 32'(aStallCnt), 32'd1);
      checkOutput("lu_br_flush_cnt", 32'(aFlushCnt), 32'd0);

      // Branch alone
      applyStimulus(6'b010000);
      checkOutput("br_ctrl", 32'(aCtrl), 32'(C_BR));
      tick();
      checkOutput("br_flush_cnt", 32'(aFlushCnt), 32'd1);
      checkOutput("br_stall_cnt", 32'(aStallCnt), 32'd1);

      // Zero-wait access is not frozen
      applyStimulus(6'b001100);
      checkOutput("zero_wait_ctrl", 32'(aCtrl), 32'(C_NONE));
      tick();
      checkOutput("zero_wait_stall_cnt", 32'(aStallCnt), 32'd1);

      // Three frozen cycles with load-use and branch ignored, then ack
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'b111000);
         checkOutput($sformatf("frozen_ctrl_%0d", i), 32'(aCtrl), 32'(C_FROZEN));
         tick();
      end
      applyStimulus(6'b001100);
      checkOutput("ack_ctrl", 32'(aCtrl), 32'(C_NONE));
      tick();
      checkOutput("frozen3_stall_cnt", 32'(aStallCnt), 32'd4);
      checkOutput("frozen3_err", 32'(aErr), 32'd0);
      checkOutput("frozen3_flush_cnt", 32'(aFlushCnt), 32'd1);

      // Watchdog timeout with MEM_TIMEOUT = 4
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(6'b001000);
         checkOutput($sformatf("wd_err_before_%0d", i), 32'(aErr), 32'd0);
         tick();
      end
      checkOutput("wd_err_set", 32'(aErr), 32'd1);
      applyStimulus(6'b011100);
      checkOutput("err_ctrl_after_ack", 32'(aCtrl), 32'(C_FROZEN));
      tick();
      checkOutput("err_sticky", 32'(aErr), 32'd1);
      checkOutput("err_stall_cnt", 32'(aStallCnt), 32'd4);
      checkOutput("err_flush_cnt", 32'(aFlushCnt), 32'd0);
      doReset();
      checkOutput("err_cleared", 32'(aErr), 32'd0);
      checkOutput("err_cleared_ctrl", 32'(aCtrl), 32'(C_NONE));

      // Halt with one load-use cycle during the drain
      applyStimulus(6'b000010);
      checkOutput("halt_req_run_ctrl", 32'(aCtrl), 32'(C_NONE));
      tick();
      applyStimulus(6'b000010);
      checkOutput("drain_ctrl", 32'(aCtrl), 32'(C_DRAIN));
      tick();
      applyStimulus(6'b100010);
      checkOutput("drain_lu_ctrl", 32'(aCtrl), 32'(C_DR_LU));
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'b000010);
         checkOutput($sformatf("drain_halted_%0d", i), 32'(aHalted), 32'd0);
         tick();
      end
      checkOutput("halted_set", 32'(aHalted), 32'd1);
      checkOutput("halt_stall_cnt", 32'(aStallCnt), 32'd1);
      applyStimulus(6'b010010);
      checkOutput("halt_br_ignored", 32'(aCtrl), 32'(C_DRAIN));
      tick();
      checkOutput("halt_hold", 32'(aHalted), 32'd1);
      checkOutput("halt_flush_cnt", 32'(aFlushCnt), 32'd0);
      applyStimulus(6'b000011);
      tick();
      checkOutput("resume_halted", 32'(aHalted), 32'd0);
      applyStimulus(6'b000000);
      checkOutput("resume_ctrl", 32'(aCtrl), 32'(C_NONE));

      // Saturation on the 4-bit stall counter
      doReset();
      for (int i = 0; i < 18; i++) begin
         applyStimulus(6'b001000);
         tick();
      end
      checkOutput("sat_stall_cnt", 32'(bStallCnt), 32'hF);
      checkOutput("sat_err", 32'(bErr), 32'd0);
      checkOutput("sat_ctrl", 32'(bCtrl), 32'(C_FROZEN));
      applyStimulus(6'b000000);
      tick();
      checkOutput("sat_hold", 32'(bStallCnt), 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rv_pipe_ctrl.md
# rv_pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. Merges the hazard unit's load-use stall, EX-stage taken-branch redirects and data-memory wait handshakes into one prioritized set of per-stage stall, flush and bubble controls. It also runs a halt/drain/resume state machine, a data-memory timeout watchdog, and saturating stall and flush performance counters. It sits beside the hazard unit and drives the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline register enables and clears.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.
- MEM_TIMEOUT, 255, consecutive frozen cycles before the error state is entered (≥2).

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_pc_load_use  in  1  load-use stall request from the hazard unit.
- i_pc_br_taken_ex  in  1  control transfer resolved taken in EX.
- i_pc_dmem_req_mem  in  1  MEM-stage instruction is accessing data memory.
- i_pc_dmem_ack  in  1  data memory completes the access this cycle.
- i_pc_halt_req  in  1  halt request, level; held until o_pc_halted.
- i_pc_resume  in  1  resume request, sampled only in HALT.
- o_pc_stall_if / o_pc_stall_id / o_pc_stall_ex / o_pc_stall_mem  out  1 each  hold the PC and the IF/ID, ID/EX, EX/MEM registers.
- o_pc_flush_id  out  1  load a bubble into IF/ID.
- o_pc_flush_ex  out  1  load a bubble into ID/EX.
- o_pc_bubble_mem  out  1  load a bubble into EX/MEM.
- o_pc_bubble_wb  out  1  load a bubble into MEM/WB.
- o_pc_redirect  out  1  PC loads the branch target; overrides o_pc_stall_if.
- o_pc_halted  out  1  state is HALT.
- o_pc_err  out  1  state is ERR.
- o_pc_stall_cnt  out  CNT_W  stall cycle count.
- o_pc_flush_cnt  out  CNT_W  redirect count.

## Operation
- Internal terms:
  - frozen = i_pc_dmem_req_mem & ~i_pc_dmem_ack.
  - lu = i_pc_load_use & ~frozen.
  - br = i_pc_br_taken_ex & ~frozen & ~lu.
- Control priority applies in RUN and DRAIN, in this order:
  - frozen: all four stalls = 1, bubble_wb = 1. Load-use and branch are ignored.
  - lu: stall_if, stall_id and stall_ex = 1, bubble_mem = 1. The branch is ignored because its operands are stale.
  - br: redirect = 1, flush_id = 1, flush_ex = 1.
- FSM, 2-bit state:
  - RUN: fetch proceeds normally. When halt_req = 1 and not frozen, go to DRAIN.
  - DRAIN: stall_if = 1 and flush_id = 1 every cycle, ORed with the priority controls.
    - The IF instruction is discarded; PC is held, so it is refetched on resume.
    - A 3-bit drain counter clears on entry and increments on each advancing cycle (~frozen & ~lu).
    - After 4 advancing cycles, go to HALT.
    - A redirect in DRAIN still updates the PC.
  - HALT: stall_if = 1, flush_id = 1; all other controls 0. On i_pc_resume = 1, go to RUN. halt_req is ignored in HALT, so resume wins when both are high.
  - ERR: all four stalls = 1, bubble_wb = 1, o_pc_err = 1. Only i_rst exits.
- Watchdog:
  - The wait counter increments each frozen cycle and clears on any non-frozen cycle.
  - When it reaches MEM_TIMEOUT-1 while still frozen, the next state is ERR.
  - The watchdog is active in RUN and DRAIN only.
- Counters (both saturate at all-ones):
  - stall_cnt increments on each RUN/DRAIN cycle with frozen or lu.
  - flush_cnt increments on each cycle with o_pc_redirect = 1.

## Timing
- All stall/flush/bubble/redirect outputs are combinational from the current state and inputs, with zero latency.
- State, drain counter, wait counter, perf counters, o_pc_halted and o_pc_err are registered; they reflect inputs one cycle later.
- Reset (synchronous): state = RUN, all counters = 0.
  - o_pc_halted and o_pc_err are 0.
  - With all inputs at 0, every control output is 0.
- Reset asserted mid-DRAIN, mid-HALT or mid-ERR returns to RUN on the next edge.
- i_pc_dmem_req_mem together with i_pc_dmem_ack in the same cycle is not frozen; that is a zero-wait access.

## Structure
- rv_configs.v gains `PC_ST_RUN = 2'd0, `PC_ST_DRAIN = 2'd1, `PC_ST_HALT = 2'd2, `PC_ST_ERR = 2'd3, plus `PC_DRAIN_CYC = 3'd4.
- rv_sat_counter sub-module (parameter W, inputs i_clk/i_rst/i_inc, output count with saturation), instantiated twice for the perf counters.

## Test plan
- load_use = 1 and br_taken_ex = 1 for one cycle → stall_if/id/ex = 1, bubble_mem = 1, redirect = 0; stall_cnt = 1 and flush_cnt = 0 after the edge.
- br_taken_ex pulse alone → redirect = flush_id = flush_ex = 1 that cycle; flush_cnt increments by 1.
- dmem_req = 1, ack held 0 for 3 cycles, then ack = 1 → all stalls and bubble_wb = 1 for exactly 3 cycles; stall_cnt = 3; no ERR.
- MEM_TIMEOUT = 4, dmem_req = 1, ack = 0 held → o_pc_err = 1 after the 4th frozen edge; it stays 1 after ack rises; i_rst clears it to 0.
- halt_req = 1 in RUN with one lu cycle during the drain → o_pc_halted rises 6 edges after the request: 1 entry edge, 4 advancing cycles, 1 lu cycle. Then resume = 1 → RUN next edge, halted = 0.
- stall_cnt preloaded near all-ones (CNT_W = 4, 16 frozen cycles) → counter holds at 4'hF.
